// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data access) arbiter for the single external memory bus.
// Round-robin on ties, 24-bit address window, wait-state watchdog and out-of-range abort.
module mem_bus_arbiter #(
  parameter int TIMEOUT   = 15,
  parameter bit OOR_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_ao,
  output logic        o_if_ack,
  output logic [31:0] o_if_di,
  input  logic        i_da_req,
  input  logic [31:0] i_da_ao,
  input  logic        i_da_wr,
  input  logic [31:0] i_da_do,
  output logic        o_da_ack,
  output logic [31:0] o_da_di,
  output logic        o_mem_as,
  output logic [31:0] o_mem_ao,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_do,
  input  logic [31:0] i_mem_di,
  input  logic        i_mem_ack,
  output logic        o_bus_err,
  output logic [31:0] o_err_ao
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_DA = 1'b1;

  logic [1:0]    r_state;
  logic          r_gnt;
  logic          r_last;
  logic [31:0]   r_ao;
  logic          r_oor;
  logic [CW-1:0] r_cnt;

  logic          w_any_req;
  logic          w_sel_da;
  logic [31:0]   w_ao;
  logic          w_oor;
  logic          w_fin;
  logic          w_err;
  logic [31:0]   w_di;

  // DA takes the bus when alone, or on a tie when IF was served last.
  assign w_any_req = i_if_req | i_da_req;
  assign w_sel_da  = i_da_req & (~i_if_req | (r_last == ID_IF));
  assign w_ao      = w_sel_da ? i_da_ao : i_if_ao;
  assign w_oor     = OOR_CHECK && (w_ao[31:24] != 8'h00);

  // An out-of-range grant spends one cycle in ACCESS with the strobe held low,
  // so its error ACK lands at the same latency as a zero-wait access.
  assign w_fin = (r_state == S_ACCESS) && (r_oor || i_mem_ack || (r_cnt == CNT_MAX));
  assign w_err = r_oor | ~i_mem_ack;
  assign w_di  = w_err ? 32'h0 : i_mem_di;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= ID_IF;
      r_last    <= ID_IF;
      r_ao      <= 32'h0;
      r_oor     <= 1'b0;
      r_cnt     <= '0;
      o_if_ack  <= 1'b0;
      o_if_di   <= 32'h0;
      o_da_ack  <= 1'b0;
      o_da_di   <= 32'h0;
      o_mem_as  <= 1'b0;
      o_mem_ao  <= 32'h0;
      o_mem_wr  <= 1'b0;
      o_mem_do  <= 32'h0;
      o_bus_err <= 1'b0;
      o_err_ao  <= 32'h0;
    end else begin
      o_if_ack  <= 1'b0;
      o_da_ack  <= 1'b0;
      o_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt    <= w_sel_da;
            r_ao     <= w_ao;
            r_oor    <= w_oor;
            r_cnt    <= '0;
            o_mem_as <= ~w_oor;
            o_mem_ao <= {8'h00, w_ao[23:0]};
            o_mem_wr <= w_sel_da & i_da_wr;
            o_mem_do <= w_sel_da ? i_da_do : 32'h0;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_fin) begin
            o_mem_as  <= 1'b0;
            o_bus_err <= w_err;
            if (w_err) o_err_ao <= r_ao;
            if (r_gnt == ID_DA) begin
              o_da_ack <= 1'b1;
              if (!o_mem_wr) o_da_di <= w_di;
            end else begin
              o_if_ack <= 1'b1;
              o_if_di  <= w_di;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
